// File: rtl/ram_pkg.sv
// Shared encodings and default sizing for the line-RAM responder.
package ram_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LINE_W = 32;
  localparam int DEF_LAT    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ACK  = 2'b10
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e;

endpackage

// File: rtl/ram_array.sv
// Line storage with a synchronous write port and a registered, enable-gated read port.
module ram_array #(
  parameter int ADDR_W = ram_pkg::DEF_ADDR_W,
  parameter int LINE_W = ram_pkg::DEF_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_q [2**ADDR_W];
  logic [LINE_W-1:0] rdata_q;

  // NOTE: storage is deliberately left out of reset so it maps onto RAM macros
  // and keeps its contents across a controller reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // The read register holds its value until the next read is performed.
  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_resp.sv
// Fixed-latency line RAM responder: captures one read or write-back request,
// waits LAT cycles, performs it and pulses ram_ack for one cycle.
module ram_resp
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int LAT    = DEF_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rdram,
  input  logic              wrram,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata,
  output logic              ram_ack,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              req_held;
  logic              mem_we, mem_re;

  // The request line that matches the captured op must stay up, else abort.
  assign req_held = (op_q == WR) ? wrram : rdram;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (wrram || rdram) state_d = WAIT;
      WAIT:    if (!req_held)          state_d = IDLE;
               else if (cnt_q == '0)   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    ram_ack = (state_q == ACK);
    mem_we  = !reset && (state_q == WAIT) && (cnt_q == '0) && req_held && (op_q == WR);
    mem_re  = !reset && (state_q == WAIT) && (cnt_q == '0) && req_held && (op_q == RD);
  end

  // Write wins over a simultaneous read; the read is taken on a later IDLE visit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      op_q    <= RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wrram) begin
            op_q    <= WR;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(LAT - 1);
          end else if (rdram) begin
            op_q   <= RD;
            addr_q <= addr;
            cnt_q  <= 4'(LAT - 1);
          end
        end
        WAIT:    if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
        default: ;
      endcase
    end
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_ram_resp.sv
// Directed bench for ram_resp at LAT=3; outputs are sampled on the falling edge.
module tb_ram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        rdram, wrram;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ram_ack, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  ram_resp #(.ADDR_W(8), .LINE_W(32), .LAT(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .rdram   (rdram),
    .wrram   (wrram),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ram_ack (ram_ack),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: raise one request, wait for ack (bounded), then drop it.
  // Returns the number of falling edges up to and including the ack.
  task automatic run_op(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        output int n, output logic busy_ok);
    logic got;
    wrram = wr; rdram = !wr; addr = a; wdata = d;
    n = 0; got = 1'b0; busy_ok = 1'b1;
    while (n < 20 && !got) begin
      @(negedge clk);
      n++;
      got = ram_ack;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    wrram = 1'b0; rdram = 1'b0;
  endtask

  int          n;
  logic        bok;
  logic        seen;

  initial begin
    reset = 1'b1; rdram = 1'b0; wrram = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'd0, busy},    32'd0);
    check("rst_ack",   {31'd0, ram_ack}, 32'd0);
    check("rst_rdata", rdata,            32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write 0x12: ack on the 4th falling edge after raising, busy throughout
    run_op(1'b1, 8'h12, 32'hDEADBEEF, n, bok);
    check("wr_lat",   n,            32'd4);
    check("wr_busy",  {31'd0, bok}, 32'd1);
    check("wr_rdata_kept", rdata,   32'd0);
    @(negedge clk);
    check("wr_idle_busy", {31'd0, busy},    32'd0);
    check("wr_idle_ack",  {31'd0, ram_ack}, 32'd0);

    // Read-back
    run_op(1'b0, 8'h12, 32'h0, n, bok);
    check("rd_lat",   n,     32'd4);
    check("rd_data",  rdata, 32'hDEADBEEF);
    @(negedge clk);

    // Write to the last-read address leaves rdata alone
    run_op(1'b1, 8'h12, 32'h0BADF00D, n, bok);
    check("wr_same_rdata", rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("rd_hold", rdata, 32'hDEADBEEF);

    // Write then read chained the cycle after ack: acks 5 cycles apart
    run_op(1'b1, 8'h05, 32'h11111111, n, bok);
    check("chain_wr_lat", n, 32'd4);
    @(negedge clk);
    rdram = 1'b1; addr = 8'h40;
    n = 1; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      seen = ram_ack;
    end
    rdram = 1'b0;
    check("chain_gap", n, 32'd5);
    @(negedge clk);
    run_op(1'b0, 8'h05, 32'h0, n, bok);
    check("chain_mem05", rdata, 32'h11111111);
    @(negedge clk);

    // Simultaneous read and write: write acked first, then the read sees new data
    rdram = 1'b1; wrram = 1'b1; addr = 8'h07; wdata = 32'h77770007;
    n = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk); n++; seen = ram_ack;
    end
    check("both_first_lat",   n,     32'd4);
    check("both_first_rdata", rdata, 32'h11111111);
    wrram = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk); n++; seen = ram_ack;
    end
    rdram = 1'b0;
    check("both_second_gap", n,     32'd5);
    check("both_read_data",  rdata, 32'h77770007);
    @(negedge clk);

    // Address and data changes after capture are ignored
    wrram = 1'b1; addr = 8'h30; wdata = 32'hAAAA5555;
    @(negedge clk);
    addr = 8'h31; wdata = 32'h5555AAAA;
    n = 1; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk); n++; seen = ram_ack;
    end
    wrram = 1'b0;
    @(negedge clk);
    run_op(1'b0, 8'h30, 32'h0, n, bok);
    check("capture_hold", rdata, 32'hAAAA5555);
    @(negedge clk);

    // Abort a write in WAIT: no ack, busy drops, array unchanged
    run_op(1'b1, 8'h20, 32'h12345678, n, bok);
    @(negedge clk);
    wrram = 1'b1; addr = 8'h20; wdata = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    wrram = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    repeat (6) begin
      if (ram_ack === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    check("abort_no_ack", {31'd0, seen}, 32'd0);
    check("abort_rdata",  rdata,         32'hAAAA5555);
    run_op(1'b0, 8'h20, 32'h0, n, bok);
    check("abort_mem20", rdata, 32'h12345678);
    @(negedge clk);

    // Reset during a read's WAIT
    rdram = 1'b1; addr = 8'h12;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy",  {31'd0, busy},    32'd0);
    check("midrst_ack",   {31'd0, ram_ack}, 32'd0);
    check("midrst_rdata", rdata,            32'd0);
    reset = 1'b0; rdram = 1'b0;
    @(negedge clk);
    run_op(1'b0, 8'h05, 32'h0, n, bok);
    check("post_rst_mem05", rdata, 32'h11111111);
    check("post_rst_lat",   n,     32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
